sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter MemStart, default 32'h0000_0000: base address of the SRAM window.
REQ-002 Parameter MemMask, default 32'h0000_FFFF: window mask; in range when (addr & ~MemMask) == MemStart.
REQ-003 clk_i  in  1  sole clock, all state on rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 instr_req_i in 1, instr_addr_i in 32: instruction-port request and word address.
REQ-006 instr_gnt_o out 1, instr_rvalid_o out 1, instr_err_o out 1, instr_rdata_o out 32: instruction grant and response.
REQ-007 data_req_i in 1, data_we_i in 1, data_be_i in 4, data_addr_i in 32, data_wdata_i in 32: data-port request.
REQ-008 data_gnt_o out 1, data_rvalid_o out 1, data_err_o out 1, data_rdata_o out 32: data grant and response.
REQ-009 mem_req_o out 1, mem_we_o out 1, mem_be_o out 4, mem_addr_o out 32, mem_wdata_o out 32: SRAM command.
REQ-010 mem_rdata_i in 32: SRAM read data, valid exactly one cycle after mem_req_o.

Function
REQ-011 Grant is combinational: at most one of instr_gnt_o/data_gnt_o high per cycle, only while its req is high.
REQ-012 Arbitration with a single requester: that requester is granted the same cycle.
REQ-013 Arbitration with both requesting: per REQ-030/REQ-031.
REQ-014 Granted in-range request: mem_req_o=1, mem_addr_o/we/be/wdata driven from the winner; instr port drives mem_we_o=0, mem_be_o=4'b1111.
REQ-015 Granted out-of-range request: granted, mem_req_o=0, error response issued.
REQ-016 No grant: mem_req_o=0, all mem_* command outputs 0.
REQ-017 Response pipeline register: resp_valid, resp_port (instr/data), resp_err; loaded on every grant, cleared when no grant.
REQ-018 Response exactly one cycle after grant: the matching rvalid high for one cycle, other port's rvalid low.
REQ-019 rdata of responding port = mem_rdata_i when resp_err=0, 32'h0 when resp_err=1; non-responding port rdata = 32'h0.
REQ-020 err asserted only together with the responding port's rvalid.
REQ-021 Writes produce a data rvalid (rdata 0), same latency as reads.
REQ-022 Back-to-back grants every cycle are supported; throughput one transaction per cycle.
REQ-023 Requester dropping req without gnt: no transaction, no response.

Reset
REQ-024 While rst_i=1: all gnt, rvalid, err, mem_req_o low; rdata and mem_* outputs 0.
REQ-025 Reset clears resp_valid, resp_err, resp_port=instr, priority pointer=instr.
REQ-026 Reset mid-transaction: pending response discarded; no rvalid in the cycle after reset deasserts.
REQ-027 Requests present while rst_i=1 are not granted.

Configuration
REQ-028 Macro SRAM_ARBITER_RR_EN selects the contention policy.
REQ-029 Priority pointer register exists only with the macro defined.
REQ-030 Macro undefined: fixed priority, instruction port always wins contention.
REQ-031 Macro defined: round-robin; on contention, grant the port not granted in the most recent contended cycle; first contention after reset goes to data. Uncontended grants do not move the pointer.

Verification
REQ-032 instr_req_i=1, addr 0x80, data idle -> instr_gnt_o=1, mem_req_o=1, mem_addr_o=0x80; next cycle instr_rvalid_o=1, instr_rdata_o=mem_rdata_i.
REQ-033 data write addr 0x100, wdata 0xDEADBEEF, be 4'b0011 -> mem_we_o=1, mem_be_o=4'b0011; next cycle data_rvalid_o=1, data_err_o=0.
REQ-034 data read addr 0x0001_0000 -> data_gnt_o=1, mem_req_o=0; next cycle data_rvalid_o=1, data_err_o=1, data_rdata_o=0.
REQ-035 Both requesting 4 cycles -> without macro: instr granted all 4, data gnt 0; with macro: data, instr, data, instr.
REQ-036 Grant in cycle N, rst_i=1 in cycle N+1 -> no rvalid in N+1 or N+2; all outputs 0 during reset.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-cycle SRAM port between an instruction
// fetch port and a data load/store port.
//
// Grants and the SRAM command are combinational; each granted transaction
// gets exactly one response on the granting port one cycle later. Requests
// outside the SRAM window are granted but answered with an error instead
// of reaching the SRAM.
//
// Configuration macro: SRAM_ARBITER_RR_EN
//   undefined : fixed priority, instruction port wins contention
//   defined   : round-robin between the ports on contention
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   instr_req_i/addr_i        instruction request
//   instr_gnt/rvalid/err/rdata_o  instruction grant and response
//   data_req/we/be/addr/wdata_i   data request
//   data_gnt/rvalid/err/rdata_o   data grant and response
//   mem_req/we/be/addr/wdata_o    SRAM command
//   mem_rdata_i               SRAM read data, one cycle after mem_req_o
module sram_arbiter #(
  parameter logic [31:0] MemStart = 32'h0000_0000,
  parameter logic [31:0] MemMask  = 32'h0000_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic        instr_err_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  localparam logic [0:0] PORT_INSTR = 1'b0;
  localparam logic [0:0] PORT_DATA  = 1'b1;

  logic          gnt_instr;
  logic          gnt_data;
  logic          gnt_any;
  logic [AW-1:0] win_addr;
  logic          in_range;
  logic          cmd_valid;

  logic          resp_valid_q;
  logic [0:0]    resp_port_q;
  logic          resp_err_q;
  logic          resp_we_q;

`ifdef SRAM_ARBITER_RR_EN
  // Port that won the most recent contended cycle; the other port wins next.
  logic [0:0]    last_win_q;
  logic          contended;

  assign contended = instr_req_i && data_req_i && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_win_q <= PORT_INSTR;
    end else if (contended) begin
      last_win_q <= gnt_data ? PORT_DATA : PORT_INSTR;
    end
  end
`endif

  // Grant selection; nothing is granted while in reset.
  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    if (!rst_i) begin
      if (instr_req_i && data_req_i) begin
`ifdef SRAM_ARBITER_RR_EN
        if (last_win_q == PORT_INSTR) begin
          gnt_data = 1'b1;
        end else begin
          gnt_instr = 1'b1;
        end
`else
        gnt_instr = 1'b1;
`endif
      end else begin
        gnt_instr = instr_req_i;
        gnt_data  = data_req_i;
      end
    end
  end

  assign gnt_any  = gnt_instr | gnt_data;
  assign win_addr = gnt_data ? data_addr_i : instr_addr_i;
  assign in_range = ((win_addr & ~MemMask) == MemStart);
  assign cmd_valid = gnt_any && in_range;

  assign instr_gnt_o = gnt_instr;
  assign data_gnt_o  = gnt_data;

  // SRAM command is zeroed whenever no in-range transaction is issued.
  assign mem_req_o   = cmd_valid;
  assign mem_we_o    = cmd_valid && gnt_data && data_we_i;
  assign mem_be_o    = !cmd_valid ? BW'(0) : (gnt_data ? data_be_i : {BW{1'b1}});
  assign mem_addr_o  = cmd_valid ? win_addr : AW'(0);
  assign mem_wdata_o = (cmd_valid && gnt_data) ? data_wdata_i : DW'(0);

  // Response pipeline stage: one entry per granted transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_port_q  <= PORT_INSTR;
      resp_err_q   <= 1'b0;
      resp_we_q    <= 1'b0;
    end else begin
      resp_valid_q <= gnt_any;
      resp_port_q  <= gnt_data ? PORT_DATA : PORT_INSTR;
      resp_err_q   <= gnt_any && !in_range;
      resp_we_q    <= gnt_data && data_we_i;
    end
  end

  logic rsp_instr;
  logic rsp_data;
  logic rdata_ok;

  // Responses are suppressed during reset so a pending one never escapes.
  assign rsp_instr = !rst_i && resp_valid_q && (resp_port_q == PORT_INSTR);
  assign rsp_data  = !rst_i && resp_valid_q && (resp_port_q == PORT_DATA);
  // Error and write responses carry no read data.
  assign rdata_ok  = !resp_err_q && !resp_we_q;

  assign instr_rvalid_o = rsp_instr;
  assign instr_err_o    = rsp_instr && resp_err_q;
  assign instr_rdata_o  = (rsp_instr && rdata_ok) ? mem_rdata_i : DW'(0);

  assign data_rvalid_o  = rsp_data;
  assign data_err_o     = rsp_data && resp_err_q;
  assign data_rdata_o   = (rsp_data && rdata_ok) ? mem_rdata_i : DW'(0);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios followed by random traffic, every
// cycle compared against a transaction-level model of the arbiter.
module tb_sram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  sram_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_err_o(instr_err_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_err_o(data_err_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: the outstanding response from last cycle, and how many
  // contended cycles have been seen since reset.
  bit          pend_valid;
  bit          pend_data;
  bit          pend_err;
  bit          pend_we;
  int unsigned n_contend;

  function automatic bit in_window(input logic [31:0] a);
    return (a & ~32'h0000_FFFF) == 32'h0000_0000;
  endfunction

  task automatic check_cycle();
    bit win_i, win_d, any, ok;
    logic [31:0] a;
    win_i = 0;
    win_d = 0;
    if (!rst_i) begin
      if (instr_req_i && data_req_i) begin
`ifdef SRAM_ARBITER_RR_EN
        // Contentions alternate, starting with the data port.
        if (n_contend % 2 == 0) win_d = 1; else win_i = 1;
`else
        win_i = 1;
`endif
      end else begin
        win_i = instr_req_i;
        win_d = data_req_i;
      end
    end
    any = win_i || win_d;
    a   = win_d ? data_addr_i : instr_addr_i;
    ok  = any && in_window(a);

    check_eq("instr_gnt", 32'(instr_gnt_o), 32'(win_i));
    check_eq("data_gnt",  32'(data_gnt_o),  32'(win_d));
    check_eq("mem_req",   32'(mem_req_o),   32'(ok));
    if (ok || !any) begin
      check_eq("mem_we",    32'(mem_we_o),  ok ? 32'(win_d && data_we_i) : 32'd0);
      check_eq("mem_be",    32'(mem_be_o),  !ok ? 32'd0 : (win_d ? 32'(data_be_i) : 32'hF));
      check_eq("mem_addr",  mem_addr_o,     ok ? a : 32'd0);
      check_eq("mem_wdata", mem_wdata_o,    (ok && win_d) ? data_wdata_i : 32'd0);
    end

    begin
      bit ri, rd;
      logic [31:0] rdv;
      ri  = !rst_i && pend_valid && !pend_data;
      rd  = !rst_i && pend_valid && pend_data;
      rdv = (pend_err || pend_we) ? 32'd0 : mem_rdata_i;
      check_eq("instr_rvalid", 32'(instr_rvalid_o), 32'(ri));
      check_eq("data_rvalid",  32'(data_rvalid_o),  32'(rd));
      check_eq("instr_err",    32'(instr_err_o),    32'(ri && pend_err));
      check_eq("data_err",     32'(data_err_o),     32'(rd && pend_err));
      check_eq("instr_rdata",  instr_rdata_o,       ri ? rdv : 32'd0);
      check_eq("data_rdata",   data_rdata_o,        rd ? rdv : 32'd0);
    end

    if (rst_i) begin
      pend_valid = 0;
      n_contend  = 0;
    end else begin
      pend_valid = any;
      pend_data  = win_d;
      pend_err   = any && !in_window(a);
      pend_we    = win_d && data_we_i;
      if (instr_req_i && data_req_i) n_contend++;
    end
  endtask

  // One cycle: drive after the rising edge, check on the falling edge.
  task automatic step(input bit r, input bit ir, input logic [31:0] ia,
                      input bit dr, input bit dwe, input logic [3:0] dbe,
                      input logic [31:0] da, input logic [31:0] dwd);
    @(posedge clk_i);
    #1;
    rst_i        = r;
    instr_req_i  = ir;
    instr_addr_i = ia;
    data_req_i   = dr;
    data_we_i    = dwe;
    data_be_i    = dbe;
    data_addr_i  = da;
    data_wdata_i = dwd;
    mem_rdata_i  = $urandom;
    @(negedge clk_i);
    check_cycle();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    return ($urandom_range(0, 3) == 0) ? (r | 32'h0001_0000) : (r & 32'h0000_FFFC);
  endfunction

  initial begin
    rst_i = 1; instr_req_i = 0; instr_addr_i = 0; data_req_i = 0;
    data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
    mem_rdata_i = 0;
    pend_valid = 0; pend_data = 0; pend_err = 0; pend_we = 0; n_contend = 0;

    // Reset with requests present: nothing may be granted.
    step(1, 1, 32'h80, 1, 0, 4'hF, 32'h40, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Instruction read, data write, out-of-window data read.
    step(0, 1, 32'h80, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
    step(0, 0, 0, 1, 0, 4'hF, 32'h0001_0000, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Four contended cycles.
    for (int i = 0; i < 4; i++)
      step(0, 1, 32'h200 + 32'(i * 4), 1, 0, 4'hF, 32'h300 + 32'(i * 4), 0);
    // Grant, then reset the next cycle: the response must be dropped.
    step(0, 1, 32'h10, 0, 0, 0, 0, 0);
    step(1, 1, 32'h14, 1, 0, 4'hF, 32'h18, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 60) == 0, 1'($urandom), rand_addr(),
           1'($urandom), 1'($urandom), 4'($urandom), rand_addr(), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
